debounce_filter: RTL and testbench

- Single-bit switch/button debouncer for the 65 MHz system domain.
- Synchronizes a raw asynchronous input (BTNx, SWx) and emits a clean level once the input has been stable for DELAY clocks.
- Also emits single-cycle rise/fall strobes, so consumers no longer keep their own prev_* registers.
- One instance per button or switch; feeds the user reset, display select and player controls.

---
 rtl/debounce_filter.sv | 99 +++++++++
 tb/tb_debounce_filter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/debounce_filter.sv
// Single-bit debouncer: synchronizes a raw switch/button and emits a clean level plus rise/fall strobes.
// Define DEBOUNCE_HOLD_EN to add the long-press "hold" flag; otherwise hold is tied low.
module debounce_filter #(
  parameter int DELAY       = 650000,
  parameter int CNT_W       = 20,
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VAL   = 1'b0,
  parameter int HOLD_CYCLES = 65000000
) (
  input  logic clock,
  input  logic reset,
  input  logic noisy,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic hold
);

  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(DELAY);

  if (DELAY < 1 || SYNC_STAGES < 2 || HOLD_CYCLES < 1 ||
      (64'd1 << CNT_W) <= 64'(DELAY)) begin : g_bad_params
    $error("debounce_filter: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   candidate;
  logic [CNT_W-1:0]       count;
  logic                   qualify;
  logic                   clean_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], noisy};
    end
  end

  // The synchronized input has held the candidate value long enough to be trusted.
  always_comb begin
    qualify = (s == candidate) && (count == DELAY_C);
    clean_d = qualify ? candidate : clean;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      candidate <= RESET_VAL;
      count     <= '0;
      clean     <= RESET_VAL;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      if (s != candidate) begin
        candidate <= s;
        count     <= '0;
      end else if (!qualify) begin
        count <= count + CNT_W'(1);
      end
      clean <= clean_d;
      rise  <= ~clean & candidate & qualify;
      fall  <= clean & ~candidate & qualify;
    end
  end

`ifdef DEBOUNCE_HOLD_EN
  localparam int               HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_C = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_d;

  // Clearing on the incoming clean value drops hold on the same edge as the fall strobe.
  always_comb begin
    hold_cnt_d = hold_cnt;
    if (!clean_d) begin
      hold_cnt_d = '0;
    end else if (clean && hold_cnt != HOLD_C) begin
      hold_cnt_d = hold_cnt + HOLD_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
      hold     <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt_d;
      hold     <= (hold_cnt_d == HOLD_C);
    end
  end
`else
  assign hold = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_filter.sv
// Directed self-checking bench for debounce_filter with DELAY=8, SYNC_STAGES=2, HOLD_CYCLES=20.
// Expected clean/rise/fall/hold are hand-derived per cycle from the step positions below.
module tb_debounce_filter;

  localparam int DELAY = 8;
  localparam int HOLD  = 20;
  localparam int LAT   = 2 + DELAY + 2;

  logic clock;
  logic reset;
  logic noisy;
  logic clean;
  logic rise;
  logic fall;
  logic hold;

  int assertCount = 0;
  int failCount   = 0;
  int holdRun     = 0;
  logic prevClean = 1'b0;

  debounce_filter #(
    .DELAY(DELAY),
    .CNT_W(4),
    .SYNC_STAGES(2),
    .RESET_VAL(1'b0),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .noisy(noisy),
    .clean(clean),
    .rise(rise),
    .fall(fall),
    .hold(hold)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic actual, input logic expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs n edges; clean switches from fromVal to toVal on edge changeAt (0 = never).
  task automatic applyStimulus(input string tag, input int n, input logic fromVal,
                               input logic toVal, input int changeAt);
    logic expClean;
    logic expHold;
    for (int i = 1; i <= n; i++) begin
      tick();
      expClean = (changeAt > 0 && i >= changeAt) ? toVal : fromVal;
      if (!expClean) holdRun = 0;
      else if (prevClean) holdRun++;
      else holdRun = 0;
      prevClean = expClean;
`ifdef DEBOUNCE_HOLD_EN
      expHold = (expClean && holdRun >= HOLD);
`else
      expHold = 1'b0;
`endif
      checkOutput({tag, "_clean"}, clean, expClean);
      checkOutput({tag, "_rise"}, rise, (i == changeAt) && !fromVal && toVal);
      checkOutput({tag, "_fall"}, fall, (i == changeAt) && fromVal && !toVal);
      checkOutput({tag, "_hold"}, hold, expHold);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_clean"}, clean, 1'b0);
    checkOutput({tag, "_rise"}, rise, 1'b0);
    checkOutput({tag, "_fall"}, fall, 1'b0);
    checkOutput({tag, "_hold"}, hold, 1'b0);
    holdRun   = 0;
    prevClean = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    noisy = 1'b0;
    #1;
    checkReset("rst_t0");

    // Reset held while the input chatters.
    for (int i = 0; i < 10; i++) begin
      noisy = ~noisy;
      tick();
      checkReset("rst_hold");
    end
    reset = 1'b1;
    noisy = 1'b0;
    applyStimulus("post_rst", 14, 1'b0, 1'b0, 0);

    noisy = 1'b1;
    applyStimulus("step_rise", 16, 1'b0, 1'b1, LAT);
    applyStimulus("steady_hi", 30, 1'b1, 1'b1, 0);

    noisy = 1'b0;
    applyStimulus("step_fall", 16, 1'b1, 1'b0, LAT);

    noisy = 1'b1;
    applyStimulus("pulse_hi", 5, 1'b0, 1'b0, 0);
    noisy = 1'b0;
    applyStimulus("pulse_lo", 20, 1'b0, 1'b0, 0);

    // Bounce 1,0,1,1,0 then settle at 1.
    noisy = 1'b1; applyStimulus("bounce", 1, 1'b0, 1'b0, 0);
    noisy = 1'b0; applyStimulus("bounce", 1, 1'b0, 1'b0, 0);
    noisy = 1'b1; applyStimulus("bounce", 2, 1'b0, 1'b0, 0);
    noisy = 1'b0; applyStimulus("bounce", 1, 1'b0, 1'b0, 0);
    noisy = 1'b1;
    applyStimulus("bounce_settle", 16, 1'b0, 1'b1, LAT);
    applyStimulus("bounce_steady", 25, 1'b1, 1'b1, 0);

    // Pending fall interrupted by an asynchronous reset mid-count.
    noisy = 1'b0;
    applyStimulus("pend_fall", 7, 1'b1, 1'b1, 0);
    #2;
    reset = 1'b0;
    #1;
    checkReset("rst_async");
    tick();
    checkReset("rst_mid");
    tick();
    checkReset("rst_mid");
    reset = 1'b1;
    applyStimulus("after_rst", 20, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
